alu_issue_stage: RTL and testbench

- Execute-issue stage directly upstream of the ALU.
- Accepts decoded operations from decode through a valid/ready handshake and buffers them in a 2-entry skid buffer.
- Drives registered op/srcA/srcB into the ALU and presents the destination tag to writeback.
- Optionally bypasses the ALU result of the retiring instruction into the next operand set.

---
 rtl/alu_pkg.sv | 38 +++
 rtl/alu_issue_fwd.sv | 21 ++
 rtl/alu_issue_stage.sv | 171 +++++++++++++++++
 tb/tb_alu_issue_stage.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU types: op encoding, data word and issue-buffer entry.
// Also holds the issue-stage state enum used by alu_issue_stage.
package alu_pkg;

  localparam int WORD_W = 8;
  localparam int REG_AW = 2;

  typedef logic [WORD_W-1:0] word;

  typedef enum logic [2:0] {
    ALU_NOP,
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_XOR,
    ALU_SLL,
    ALU_SRL
  } e_alu_op;

  typedef enum logic [1:0] {
    EMPTY,
    ONE,
    FULL
  } e_issue_state;

  typedef struct packed {
    e_alu_op           op;
    word               a;
    word               b;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic              b_reg;
    logic [REG_AW-1:0] rd;
    logic              we;
  } issue_entry_t;

endpackage

// File: rtl/alu_issue_fwd.sv
// Operand bypass mux: swaps in the retiring ALU result on a tag match.
// Instantiated by alu_issue_stage only when ALU_ISSUE_BYPASS_EN is set.
module alu_issue_fwd #(
  parameter int WIDTH  = 8,
  parameter int REG_AW = 2
) (
  input  logic [REG_AW-1:0] rs,
  input  logic              use_reg,
  input  logic [WIDTH-1:0]  val,
  input  logic              wb_en,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic [WIDTH-1:0]  wb_data,
  output logic [WIDTH-1:0]  fwd
);

  logic hit;

  assign hit = wb_en & use_reg & (rs == wb_rd);
  assign fwd = hit ? wb_data : val;

endmodule

// File: rtl/alu_issue_stage.sv
// ALU issue stage: 2-entry skid buffer between decode and ALU/writeback.
// Define ALU_ISSUE_BYPASS_EN to forward the retiring result into M.
module alu_issue_stage
  import alu_pkg::word;
  import alu_pkg::e_alu_op;
  import alu_pkg::e_issue_state;
  import alu_pkg::issue_entry_t;
  import alu_pkg::ALU_NOP;
  import alu_pkg::EMPTY;
  import alu_pkg::ONE;
  import alu_pkg::FULL;
#(
  parameter int WIDTH  = 8,
  parameter int REG_AW = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_op,
  input  logic [WIDTH-1:0]  in_a,
  input  logic [WIDTH-1:0]  in_b,
  input  logic [REG_AW-1:0] in_rs1,
  input  logic [REG_AW-1:0] in_rs2,
  input  logic              in_b_reg,
  input  logic [REG_AW-1:0] in_rd,
  input  logic              in_we,
  output logic [2:0]        alu_op,
  output logic [WIDTH-1:0]  alu_a,
  output logic [WIDTH-1:0]  alu_b,
  input  logic [WIDTH-1:0]  alu_result,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [REG_AW-1:0] out_rd,
  output logic              out_we,
  output logic [1:0]        occupancy
);

  e_issue_state state, state_n;
  issue_entry_t m_q, s_q, in_e, src_e, m_n;
  logic ready_q, accept, retire;
  logic load_in, load_s, load_m_s;

  assign out_valid = (state != EMPTY);
  assign retire    = out_valid & out_ready;
  assign accept    = in_valid & ready_q;
  assign in_ready  = ready_q;

  always_comb begin
    in_e    = '0;
    in_e.op = e_alu_op'(in_op);
    in_e.a  = in_a;
    in_e.b  = in_b;
    in_e.rd = in_rd;
    in_e.we = in_we;
`ifdef ALU_ISSUE_BYPASS_EN
    in_e.rs1   = in_rs1;
    in_e.rs2   = in_rs2;
    in_e.b_reg = in_b_reg;
`endif
  end

  always_comb begin
    state_n  = state;
    load_in  = 1'b0;
    load_s   = 1'b0;
    load_m_s = 1'b0;
    unique case (state)
      EMPTY: begin
        if (accept) begin
          load_in = 1'b1;
          state_n = ONE;
        end
      end
      ONE: begin
        if (accept && retire) begin
          load_in = 1'b1;
        end else if (accept) begin
          load_s  = 1'b1;
          state_n = FULL;
        end else if (retire) begin
          state_n = EMPTY;
        end
      end
      FULL: begin
        if (retire) begin
          load_m_s = 1'b1;
          state_n  = ONE;
        end
      end
      default: state_n = EMPTY;
    endcase
    // flush kills everything, including a same-cycle accept
    if (flush) begin
      state_n  = EMPTY;
      load_in  = 1'b0;
      load_s   = 1'b0;
      load_m_s = 1'b0;
    end
  end

  assign src_e = load_m_s ? s_q : in_e;

`ifdef ALU_ISSUE_BYPASS_EN
  logic [WIDTH-1:0] fwd_a, fwd_b;
  logic wb_fwd;

  assign wb_fwd = retire & out_we;

  alu_issue_fwd #(.WIDTH(WIDTH), .REG_AW(REG_AW)) u_fwd_a (
    .rs      (src_e.rs1),
    .use_reg (1'b1),
    .val     (src_e.a),
    .wb_en   (wb_fwd),
    .wb_rd   (m_q.rd),
    .wb_data (alu_result),
    .fwd     (fwd_a)
  );

  alu_issue_fwd #(.WIDTH(WIDTH), .REG_AW(REG_AW)) u_fwd_b (
    .rs      (src_e.rs2),
    .use_reg (src_e.b_reg),
    .val     (src_e.b),
    .wb_en   (wb_fwd),
    .wb_rd   (m_q.rd),
    .wb_data (alu_result),
    .fwd     (fwd_b)
  );

  always_comb begin
    m_n   = src_e;
    m_n.a = fwd_a;
    m_n.b = fwd_b;
  end
`else
  logic unused_in;

  assign unused_in = ^{in_rs1, in_rs2, in_b_reg, alu_result};
  assign m_n = src_e;
`endif

  logic unused_m;

  assign unused_m = ^{m_q.rs1, m_q.rs2, m_q.b_reg};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= EMPTY;
      ready_q <= 1'b0;
      m_q     <= '0;
      s_q     <= '0;
    end else begin
      state   <= state_n;
      ready_q <= (state_n != FULL);
      if (load_in || load_m_s) m_q <= m_n;
      if (load_s) s_q <= in_e;
    end
  end

  // operands hold their last value while M is empty
  assign alu_op = out_valid ? m_q.op : ALU_NOP;
  assign alu_a  = m_q.a;
  assign alu_b  = m_q.b;
  assign out_rd = m_q.rd;
  assign out_we = out_valid & m_q.we;

  assign occupancy = (state == FULL) ? 2'd2 :
                     (state == ONE)  ? 2'd1 : 2'd0;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Scoreboard bench for alu_issue_stage with a FIFO reference model.
// Honours ALU_ISSUE_BYPASS_EN for the expected forwarded operands.
module tb_alu_issue_stage;
  import alu_pkg::*;

`ifdef ALU_ISSUE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       flush = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [2:0] in_op = '0;
  logic [7:0] in_a = '0, in_b = '0;
  logic [1:0] in_rs1 = '0, in_rs2 = '0, in_rd = '0;
  logic       in_b_reg = 1'b0, in_we = 1'b0;
  logic [2:0] alu_op;
  logic [7:0] alu_a, alu_b, alu_result;
  logic       out_valid, out_we;
  logic       out_ready = 1'b0;
  logic [1:0] out_rd, occupancy;

  always #5 clk = ~clk;

  alu_issue_stage #(.WIDTH(8), .REG_AW(2)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_a(in_a), .in_b(in_b),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_b_reg(in_b_reg),
    .in_rd(in_rd), .in_we(in_we),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
    .alu_result(alu_result),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_rd(out_rd), .out_we(out_we), .occupancy(occupancy)
  );

  function automatic logic [7:0] alu_f(logic [2:0] op, logic [7:0] a, logic [7:0] b);
    case (op)
      3'd1: return a + b;
      3'd2: return a - b;
      3'd3: return a & b;
      3'd4: return a | b;
      3'd5: return a ^ b;
      3'd6: return a << b[2:0];
      3'd7: return a >> b[2:0];
      default: return 8'h00;
    endcase
  endfunction

  assign alu_result = alu_f(alu_op, alu_a, alu_b);

  typedef struct {
    logic [2:0] op;
    logic [7:0] a, b;
    logic [1:0] rs1, rs2;
    logic       breg;
    logic [1:0] rd;
    logic       we;
    int         acc;
  } op_t;

  op_t sb[$];
  int  cyc = 0;
  int  n_cmp = 0, n_bad = 0;
  bit  mon_en = 1'b0;

  int         last_ret = -1;
  logic [1:0] last_rd = '0;
  logic       last_we = 1'b0;
  logic [7:0] last_res = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: state checks every cycle, pops the scoreboard on retire.
  int         m_cnt;
  op_t        m_e;
  logic [7:0] m_ea, m_eb;
  bit         m_fw;

  always @(negedge clk) begin
    if (mon_en) begin
      m_cnt = sb.size();
      chk("occupancy", occupancy, m_cnt);
      chk("in_ready", in_ready, m_cnt < 2);
      chk("out_valid", out_valid, m_cnt > 0);
      if (m_cnt == 0) begin
        chk("idle_alu_op", alu_op, ALU_NOP);
        chk("idle_out_we", out_we, 0);
      end
      if (out_valid && out_ready && m_cnt > 0) begin
        m_e  = sb.pop_front();
        // forwarded only if it entered M as its predecessor retired
        m_fw = BYP && (m_e.acc <= last_ret) && last_we;
        m_ea = (m_fw && m_e.rs1 == last_rd) ? last_res : m_e.a;
        m_eb = (m_fw && m_e.breg && m_e.rs2 == last_rd) ? last_res : m_e.b;
        chk("alu_op", alu_op, m_e.op);
        chk("alu_a", alu_a, m_ea);
        chk("alu_b", alu_b, m_eb);
        chk("out_rd", out_rd, m_e.rd);
        chk("out_we", out_we, m_e.we);
        last_ret = cyc;
        last_rd  = m_e.rd;
        last_we  = m_e.we;
        last_res = alu_f(m_e.op, m_ea, m_eb);
      end
    end
  end

  task automatic drive(input bit v, input logic [2:0] op,
                       input logic [7:0] a, input logic [7:0] b,
                       input logic [1:0] rs1, input logic [1:0] rs2,
                       input bit breg, input logic [1:0] rd, input bit we,
                       input bit ordy, input bit fl, output bit acc);
    bit rdy;
    @(posedge clk);
    #1;
    in_valid = v; in_op = op; in_a = a; in_b = b;
    in_rs1 = rs1; in_rs2 = rs2; in_b_reg = breg;
    in_rd = rd; in_we = we; out_ready = ordy; flush = fl;
    rdy = (sb.size() < 2);
    @(negedge clk);
    #1;
    acc = v && rdy && !fl;
    if (fl) sb.delete();
    else if (acc) sb.push_back('{op, a, b, rs1, rs2, breg, rd, we, cyc});
  endtask

  task automatic idle(input int n, input bit ordy);
    bit acc;
    for (int i = 0; i < n; i++)
      drive(0, 3'd0, 8'h0, 8'h0, 2'd0, 2'd0, 0, 2'd0, 0, ordy, 0, acc);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  bit         acc;
  bit         pend;
  logic [2:0] p_op;
  logic [7:0] p_a, p_b;
  logic [1:0] p_rs1, p_rs2, p_rd;
  bit         p_breg, p_we, p_v, p_rdy, p_fl;

  initial begin
    #2 rst_n = 1'b0;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_alu_op", alu_op, ALU_NOP);
    chk("rst_occupancy", occupancy, 0);
    chk("rst_out_we", out_we, 0);
    #19 rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_in_ready", in_ready, 1);
    mon_en = 1'b1;

    // single ADD
    drive(1, ALU_ADD, 8'h05, 8'h03, 2'd0, 2'd0, 1, 2'd1, 1, 1, 0, acc);
    idle(2, 1);

    // back-pressure: SUB, AND accepted; OR held until space
    drive(1, ALU_SUB, 8'h20, 8'h07, 2'd0, 2'd1, 1, 2'd1, 1, 0, 0, acc);
    drive(1, ALU_AND, 8'h3C, 8'h0F, 2'd1, 2'd0, 1, 2'd2, 1, 0, 0, acc);
    drive(1, ALU_OR, 8'h50, 8'h05, 2'd3, 2'd3, 1, 2'd3, 1, 0, 0, acc);
    chk("bp_or_held", acc, 0);
    acc = 0;
    for (int i = 0; i < 6 && !acc; i++)
      drive(1, ALU_OR, 8'h50, 8'h05, 2'd3, 2'd3, 1, 2'd3, 1, 1, 0, acc);
    chk("bp_or_accepted", acc, 1);
    idle(4, 1);

    // flush while full with an op on the input
    drive(1, ALU_ADD, 8'h11, 8'h22, 2'd0, 2'd0, 1, 2'd0, 1, 0, 0, acc);
    drive(1, ALU_ADD, 8'h33, 8'h44, 2'd0, 2'd0, 1, 2'd1, 1, 0, 0, acc);
    drive(1, ALU_XOR, 8'hFF, 8'h0F, 2'd0, 2'd0, 1, 2'd2, 1, 0, 1, acc);
    idle(3, 1);

    // bypass pair, then an immediate that must not be forwarded
    drive(1, ALU_ADD, 8'h04, 8'h06, 2'd0, 2'd1, 1, 2'd2, 1, 0, 0, acc);
    drive(1, ALU_SUB, 8'h00, 8'h01, 2'd2, 2'd0, 1, 2'd3, 1, 1, 0, acc);
    drive(1, ALU_OR, 8'h01, 8'h07, 2'd1, 2'd3, 0, 2'd0, 1, 1, 0, acc);
    idle(3, 1);

    // asynchronous reset in the middle of traffic
    drive(1, ALU_ADD, 8'h01, 8'h02, 2'd0, 2'd0, 1, 2'd1, 1, 0, 0, acc);
    drive(1, ALU_ADD, 8'h03, 8'h04, 2'd0, 2'd0, 1, 2'd2, 1, 0, 0, acc);
    @(posedge clk);
    #3;
    mon_en = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_alu_op", alu_op, ALU_NOP);
    chk("mid_rst_occupancy", occupancy, 0);
    chk("mid_rst_out_we", out_we, 0);
    sb.delete();
    last_ret = cyc;
    last_we = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("mid_rst_in_ready", in_ready, 1);
    mon_en = 1'b1;

    // random traffic; decode holds an op until accepted
    pend = 0;
    for (int i = 0; i < 600; i++) begin
      if (!pend) begin
        p_v = ($urandom_range(0, 3) != 0);
        p_op = 3'($urandom_range(0, 7));
        p_a = 8'($urandom); p_b = 8'($urandom);
        p_rs1 = 2'($urandom); p_rs2 = 2'($urandom);
        p_rd = 2'($urandom); p_breg = 1'($urandom);
        p_we = ($urandom_range(0, 4) != 0);
      end
      p_rdy = ($urandom_range(0, 9) < 6);
      p_fl = ($urandom_range(0, 24) == 0);
      drive(p_v, p_op, p_a, p_b, p_rs1, p_rs2, p_breg, p_rd, p_we, p_rdy, p_fl, acc);
      pend = p_v && !acc && !p_fl;
    end

    idle(6, 1);
    chk("drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
